// File: rtl/shr_seq_ctrl.sv
// Burst scheduler for the serial pattern output stage: optional clear phase,
// then N trigger bursts separated by a programmable gap, each closed by the stage's syn pulse.
module shr_seq_ctrl #(
    parameter int unsigned LEN_W      = 10,
    parameter int unsigned REP_W      = 8,
    parameter int unsigned GAP_W      = 16,
    parameter int unsigned TMO_MARGIN = 16
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [REP_W-1:0] cfg_repeat,
    input  logic [GAP_W-1:0] cfg_gap,
    input  logic [7:0]       cfg_pre_clr,
    input  logic             cfg_clr_val,
    input  logic             syn_in,
    output logic             trig,
    output logic [LEN_W-1:0] seq_length,
    output logic             clr_mode,
    output logic             clr_2_one,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [REP_W-1:0] burst_cnt
);

    localparam int unsigned TMO_W = $clog2((2 ** LEN_W) + TMO_MARGIN);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PRECLR   = 3'd1,
        TRIG     = 3'd2,
        WAIT_SYN = 3'd3,
        GAP      = 3'd4,
        DRAIN    = 3'd5
    } state_t;

    state_t             state, state_n;
    logic               syn_q;
    logic               syn_rise;
    logic [REP_W-1:0]   reps_q, reps_n;
    logic [GAP_W-1:0]   gap_q, gap_n;
    logic [GAP_W-1:0]   cnt_q, cnt_n;
    logic [TMO_W-1:0]   tmo_q, tmo_n;
    logic [LEN_W-1:0]   len_n;
    logic               clr_val_n;
    logic [REP_W-1:0]   burst_n;
    logic [REP_W-1:0]   burst_inc;
    logic               done_n;
    logic               err_n;

    assign syn_rise  = syn_in & ~syn_q;
    assign burst_inc = (burst_cnt == {REP_W{1'b1}}) ? burst_cnt : burst_cnt + REP_W'(1);

    // State, working registers and registered outputs
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state      <= IDLE;
            syn_q      <= 1'b0;
            reps_q     <= '0;
            gap_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            seq_length <= '0;
            clr_2_one  <= 1'b0;
            burst_cnt  <= '0;
            trig       <= 1'b0;
            clr_mode   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_n;
            syn_q      <= syn_in;
            reps_q     <= reps_n;
            gap_q      <= gap_n;
            cnt_q      <= cnt_n;
            tmo_q      <= tmo_n;
            seq_length <= len_n;
            clr_2_one  <= clr_val_n;
            burst_cnt  <= burst_n;
            trig       <= (state_n == TRIG);
            clr_mode   <= (state_n == PRECLR);
            busy       <= (state_n != IDLE);
            done       <= done_n;
            err        <= err_n;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_n   = state;
        reps_n    = reps_q;
        gap_n     = gap_q;
        cnt_n     = cnt_q;
        tmo_n     = tmo_q;
        len_n     = seq_length;
        clr_val_n = clr_2_one;
        burst_n   = burst_cnt;
        done_n    = 1'b0;
        err_n     = 1'b0;

        unique case (state)
            IDLE: begin
                if (start && !abort) begin
                    if (cfg_len == '0) begin
                        err_n = 1'b1;
                    end else begin
                        len_n     = cfg_len;
                        clr_val_n = cfg_clr_val;
                        reps_n    = (cfg_repeat == '0) ? REP_W'(1) : cfg_repeat;
                        gap_n     = cfg_gap;
                        burst_n   = '0;
                        if (cfg_pre_clr != 8'd0) begin
                            cnt_n   = GAP_W'(cfg_pre_clr);
                            state_n = PRECLR;
                        end else begin
                            state_n = TRIG;
                        end
                    end
                end
            end

            PRECLR: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (cnt_q == GAP_W'(1)) begin
                    state_n = TRIG;
                end else begin
                    cnt_n = cnt_q - GAP_W'(1);
                end
            end

            TRIG: begin
                if (abort) begin
                    state_n = IDLE;
                end else begin
                    // The TRIG cycle itself counts toward the timeout window
                    tmo_n   = TMO_W'(seq_length) + TMO_W'(TMO_MARGIN - 1);
                    state_n = WAIT_SYN;
                end
            end

            WAIT_SYN: begin
                if (syn_rise) begin
                    burst_n = burst_inc;
                    if (burst_inc == reps_q) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else if (abort) begin
                        state_n = IDLE;
                    end else if (gap_q != '0) begin
                        cnt_n   = gap_q;
                        state_n = GAP;
                    end else begin
                        state_n = TRIG;
                    end
                end else if (tmo_q == TMO_W'(1)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo_q - TMO_W'(1);
                    if (abort) begin
                        state_n = DRAIN;
                    end
                end
            end

            GAP: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (cnt_q == GAP_W'(1)) begin
                    state_n = TRIG;
                end else begin
                    cnt_n = cnt_q - GAP_W'(1);
                end
            end

            DRAIN: begin
                // Stage is mid-burst; let it finish before releasing busy
                if (syn_rise) begin
                    state_n = IDLE;
                end else if (tmo_q == TMO_W'(1)) begin
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    tmo_n = tmo_q - TMO_W'(1);
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
